// File: rtl/mshr_repair_ctrl.sv
// Repair controller for a single MSHR entry: issues one next-level access,
// retries on error/timeout, then fills the cache and writes back to the ROB.
module mshr_repair_ctrl #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int MAX_RETRIES    = 2,
    parameter int ROB_ENTRIES    = 64,
    parameter int RIW            = $clog2(ROB_ENTRIES)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           repair_req,
    input  logic [31:0]    repair_req_addr,
    input  logic [31:0]    repair_req_data,
    input  logic [RIW-1:0] repair_req_rob_idx,
    input  logic           repair_is_store,
    output logic           repair_ack,
    output logic           repair_complete,
    output logic           mem_req_valid,
    input  logic           mem_req_ready,
    output logic [31:0]    mem_req_addr,
    output logic           mem_req_we,
    output logic [31:0]    mem_req_wdata,
    input  logic           mem_resp_valid,
    input  logic [31:0]    mem_resp_data,
    input  logic           mem_resp_err,
    output logic           fill_valid,
    output logic [31:0]    fill_addr,
    output logic [31:0]    fill_data,
    output logic           wb_valid,
    output logic [RIW-1:0] wb_rob_idx,
    output logic [31:0]    wb_data,
    output logic           wb_exc,
    output logic           busy
);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int CW = ($clog2(MAX_RETRIES + 1) > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] RMAX = CW'(MAX_RETRIES);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state, nstate;
    logic [TW-1:0]    timer;
    logic [CW-1:0]    retry_cnt;
    logic             err_flag;
    logic [31:0]      lat_addr, lat_data, rdata;
    logic [RIW-1:0]   lat_rob;
    logic             lat_store;
    logic             resp_ok, attempt_fail, can_retry;

    // A good response wins over a timer expiring in the same cycle.
    assign resp_ok      = (state == WAIT) && mem_resp_valid && !mem_resp_err;
    assign attempt_fail = (state == WAIT) && !resp_ok &&
                          ((mem_resp_valid && mem_resp_err) || (timer == TMAX));
    assign can_retry    = (retry_cnt < RMAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (repair_req) nstate = ISSUE;
            ISSUE:   if (mem_req_ready) nstate = WAIT;
            WAIT:    if (resp_ok) nstate = RESP;
                     else if (attempt_fail) nstate = can_retry ? ISSUE : RESP;
            RESP:    nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer     <= '0;
            retry_cnt <= '0;
            err_flag  <= 1'b0;
            lat_addr  <= '0;
            lat_data  <= '0;
            lat_rob   <= '0;
            lat_store <= 1'b0;
            rdata     <= '0;
        end else begin
            case (state)
                IDLE: if (repair_req) begin
                    lat_addr  <= repair_req_addr;
                    lat_data  <= repair_req_data;
                    lat_rob   <= repair_req_rob_idx;
                    lat_store <= repair_is_store;
                    retry_cnt <= '0;
                    err_flag  <= 1'b0;
                    rdata     <= '0;
                end
                ISSUE: if (mem_req_ready) timer <= '0;
                WAIT: begin
                    // Saturate rather than wrap; the FSM leaves WAIT at TMAX anyway.
                    if (timer != TMAX) timer <= timer + TW'(1);
                    if (resp_ok) begin
                        rdata    <= mem_resp_data;
                        err_flag <= 1'b0;
                    end else if (attempt_fail) begin
                        if (can_retry) retry_cnt <= retry_cnt + CW'(1);
                        else           err_flag  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // repair_ack is the only combinational path; gated so it stays low in reset.
    assign repair_ack = rst_n && (state == IDLE) && repair_req;

    always_comb begin
        repair_complete = 1'b0;
        mem_req_valid   = 1'b0;
        mem_req_addr    = '0;
        mem_req_we      = 1'b0;
        mem_req_wdata   = '0;
        fill_valid      = 1'b0;
        fill_addr       = '0;
        fill_data       = '0;
        wb_valid        = 1'b0;
        wb_rob_idx      = '0;
        wb_data         = '0;
        wb_exc          = 1'b0;
        busy            = (state != IDLE);
        case (state)
            ISSUE: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = lat_addr;
                mem_req_we    = lat_store;
                mem_req_wdata = lat_store ? lat_data : 32'h0;
            end
            RESP: begin
                repair_complete = 1'b1;
                wb_valid        = 1'b1;
                wb_rob_idx      = lat_rob;
                wb_data         = lat_store ? 32'h0 : rdata;
                wb_exc          = err_flag;
                fill_valid      = !err_flag;
                fill_addr       = lat_addr;
                fill_data       = lat_store ? lat_data : rdata;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mshr_repair_ctrl.sv
// Directed bench for mshr_repair_ctrl: per-cycle vector table plus retry,
// timeout, back-to-back and mid-transaction reset sequences.
module tb_mshr_repair_ctrl;
    localparam int RIW = 6;
    localparam int OW  = 174;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           repair_req;
    logic [31:0]    repair_req_addr, repair_req_data;
    logic [RIW-1:0] repair_req_rob_idx;
    logic           repair_is_store;
    logic           repair_ack, repair_complete;
    logic           mem_req_valid, mem_req_ready, mem_req_we;
    logic [31:0]    mem_req_addr, mem_req_wdata;
    logic           mem_resp_valid, mem_resp_err;
    logic [31:0]    mem_resp_data;
    logic           fill_valid, wb_valid, wb_exc, busy;
    logic [31:0]    fill_addr, fill_data, wb_data;
    logic [RIW-1:0] wb_rob_idx;

    mshr_repair_ctrl #(.TIMEOUT_CYCLES(4), .MAX_RETRIES(2), .ROB_ENTRIES(64), .RIW(RIW)) dut (
        .clk(clk), .rst_n(rst_n),
        .repair_req(repair_req), .repair_req_addr(repair_req_addr),
        .repair_req_data(repair_req_data), .repair_req_rob_idx(repair_req_rob_idx),
        .repair_is_store(repair_is_store), .repair_ack(repair_ack),
        .repair_complete(repair_complete), .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_we(mem_req_we), .mem_req_wdata(mem_req_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .mem_resp_err(mem_resp_err), .fill_valid(fill_valid),
        .fill_addr(fill_addr), .fill_data(fill_data), .wb_valid(wb_valid),
        .wb_rob_idx(wb_rob_idx), .wb_data(wb_data), .wb_exc(wb_exc), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [OW-1:0] obus;
    assign obus = {repair_ack, repair_complete, mem_req_valid, mem_req_addr, mem_req_we,
                   mem_req_wdata, fill_valid, fill_addr, fill_data, wb_valid, wb_rob_idx,
                   wb_data, wb_exc, busy};

    typedef struct {
        logic           req;
        logic [31:0]    addr, data;
        logic [RIW-1:0] rob;
        logic           st, rdy, rv;
        logic [31:0]    rd;
        logic [OW-1:0]  exp;
    } vec_t;

    int nvec = 0;
    int nerr = 0;

    function automatic logic [OW-1:0] ex(input logic ack, cmp, mv, input logic [31:0] ma,
                                         input logic mwe, input logic [31:0] mwd,
                                         input logic fv, input logic [31:0] fa, fd,
                                         input logic wv, input logic [RIW-1:0] wr,
                                         input logic [31:0] wd, input logic wx, bsy);
        return {ack, cmp, mv, ma, mwe, mwd, fv, fa, fd, wv, wr, wd, wx, bsy};
    endfunction

    function automatic vec_t row(input logic req, input logic [31:0] a, d,
                                 input logic [RIW-1:0] r, input logic st, rdy, rv,
                                 input logic [31:0] rd, input logic [OW-1:0] e);
        vec_t v;
        v.req = req; v.addr = a; v.data = d; v.rob = r; v.st = st;
        v.rdy = rdy; v.rv = rv; v.rd = rd; v.exp = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] expv);
        nvec++;
        if (act !== expv) begin
            nerr++;
            $display("FAIL %s: got %0h, required %0h", name, act, expv);
        end
    endtask

    task automatic idle_inputs();
        repair_req = 0; repair_req_addr = 0; repair_req_data = 0; repair_req_rob_idx = 0;
        repair_is_store = 0; mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;
        mem_resp_err = 0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Issues a load, answers each handshake `delay` cycles later (never if <0),
    // erroring the first n_err responses; reports what the DUT did.
    task automatic run_txn(input logic [31:0] addr, input int n_err, input int delay,
                           output int n_req, output int gap, output logic exc,
                           output logic fill, output logic done);
        int resp_at = -1, first_hs = -1;
        n_req = 0; gap = -1; exc = 0; fill = 0; done = 0;
        repair_req = 1; repair_req_addr = addr; repair_req_rob_idx = 6'd3;
        repair_is_store = 0; mem_req_ready = 1; #1;
        check("txn_ack", {191'b0, repair_ack}, 192'd1);
        tick();
        repair_req = 0;
        for (int cyc = 1; cyc < 100 && !done; cyc++) begin
            mem_resp_valid = 0; mem_resp_err = 0; mem_resp_data = 0;
            if (cyc == resp_at) begin
                mem_resp_valid = 1;
                mem_resp_err   = (n_req <= n_err);
                mem_resp_data  = 32'hC0DE0000 | n_req;
                resp_at = -1;
            end
            #1;
            if (mem_req_valid) begin
                n_req++;
                if (first_hs < 0) first_hs = cyc;
                else if (gap < 0) gap = cyc - first_hs;
                if (delay >= 0) resp_at = cyc + delay;
            end
            if (repair_complete) begin
                done = 1; exc = wb_exc; fill = fill_valid;
            end
            tick();
        end
        idle_inputs();
    endtask

    vec_t vecs[$];
    int   n_req, gap;
    logic exc, fill, done;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        rst_n = 0;
        repair_req = 1;
        #12;
        check("reset_outputs", {18'b0, obus}, 192'd0);

        // Load then store, one row per cycle; row 0 is the first edge after reset release.
        vecs.push_back(row(1, 32'h1000, 0, 5, 0, 0, 0, 0, ex(1,0,0,0,0,0,0,0,0,0,0,0,0,0)));
        vecs.push_back(row(0, 0, 0, 0, 0, 1, 0, 0, ex(0,0,1,32'h1000,0,0,0,0,0,0,0,0,0,1)));
        vecs.push_back(row(0, 0, 0, 0, 0, 1, 1, 32'hDEADBEEF, ex(0,0,0,0,0,0,0,0,0,0,0,0,0,1)));
        vecs.push_back(row(0, 0, 0, 0, 0, 1, 0, 0,
            ex(0,1,0,0,0,0,1,32'h1000,32'hDEADBEEF,1,5,32'hDEADBEEF,0,1)));
        vecs.push_back(row(0, 0, 0, 0, 0, 1, 1, 32'h55, ex(0,0,0,0,0,0,0,0,0,0,0,0,0,0)));
        vecs.push_back(row(0, 0, 0, 0, 0, 1, 0, 0, ex(0,0,0,0,0,0,0,0,0,0,0,0,0,0)));
        vecs.push_back(row(1, 32'h2004, 32'h12345678, 9, 1, 0, 0, 0, ex(1,0,0,0,0,0,0,0,0,0,0,0,0,0)));
        for (int i = 0; i < 3; i++)
            vecs.push_back(row(0, 0, 0, 0, 0, 0, 0, 0,
                ex(0,0,1,32'h2004,1,32'h12345678,0,0,0,0,0,0,0,1)));
        vecs.push_back(row(0, 0, 0, 0, 0, 1, 0, 0, ex(0,0,1,32'h2004,1,32'h12345678,0,0,0,0,0,0,0,1)));
        vecs.push_back(row(0, 0, 0, 0, 0, 1, 1, 32'hAAAA5555, ex(0,0,0,0,0,0,0,0,0,0,0,0,0,1)));
        vecs.push_back(row(0, 0, 0, 0, 0, 1, 0, 0,
            ex(0,1,0,0,0,0,1,32'h2004,32'h12345678,1,9,32'h0,0,1)));
        vecs.push_back(row(0, 0, 0, 0, 0, 1, 0, 0, ex(0,0,0,0,0,0,0,0,0,0,0,0,0,0)));

        @(negedge clk);
        rst_n = 1;
        foreach (vecs[i]) begin
            repair_req = vecs[i].req; repair_req_addr = vecs[i].addr;
            repair_req_data = vecs[i].data; repair_req_rob_idx = vecs[i].rob;
            repair_is_store = vecs[i].st; mem_req_ready = vecs[i].rdy;
            mem_resp_valid = vecs[i].rv; mem_resp_data = vecs[i].rd; mem_resp_err = 0;
            #1;
            check($sformatf("vec%0d", i), {18'b0, obus}, {18'b0, vecs[i].exp});
            tick();
        end
        idle_inputs();

        run_txn(32'h3000, 2, 1, n_req, gap, exc, fill, done);
        check("err2_ok3_reqs", 192'(n_req), 192'd3);
        check("err2_ok3_gap", 192'(gap), 192'd2);
        check("err2_ok3_result", {189'b0, done, exc, fill}, {189'b0, 3'b101});

        run_txn(32'h3100, 3, 1, n_req, gap, exc, fill, done);
        check("err3_reqs", 192'(n_req), 192'd3);
        check("err3_result", {189'b0, done, exc, fill}, {189'b0, 3'b110});

        run_txn(32'h3200, 0, -1, n_req, gap, exc, fill, done);
        check("timeout_reqs", 192'(n_req), 192'd3);
        check("timeout_gap", 192'(gap), 192'd5);
        check("timeout_result", {189'b0, done, exc, fill}, {189'b0, 3'b110});

        run_txn(32'h3300, 0, 4, n_req, gap, exc, fill, done);
        check("expiry_resp_reqs", 192'(n_req), 192'd1);
        check("expiry_resp_result", {189'b0, done, exc, fill}, {189'b0, 3'b101});

        // Back-to-back: request held high, response one cycle after each handshake.
        begin
            int first_ack = -1, second_ack = -1, first_cmp = -1, bad_ack = 0, resp_at = -1;
            repair_req = 1; repair_req_addr = 32'h4000; mem_req_ready = 1;
            for (int cyc = 0; cyc < 12; cyc++) begin
                mem_resp_valid = (cyc == resp_at);
                mem_resp_data  = 32'h4444;
                #1;
                if (repair_ack && busy) bad_ack++;
                if (repair_ack) begin
                    if (first_ack < 0) first_ack = cyc;
                    else if (second_ack < 0) second_ack = cyc;
                end
                if (repair_complete && first_cmp < 0) first_cmp = cyc;
                if (mem_req_valid) resp_at = cyc + 1;
                tick();
            end
            idle_inputs();
            check("b2b_first_ack", 192'(first_ack), 192'd0);
            check("b2b_first_cmp", 192'(first_cmp), 192'd3);
            check("b2b_second_ack", 192'(second_ack), 192'(first_cmp + 1));
            check("b2b_ack_while_busy", 192'(bad_ack), 192'd0);
            repeat (4) tick();
        end

        // Reset asserted mid-WAIT, asynchronously to the clock.
        repair_req = 1; repair_req_addr = 32'h5000; mem_req_ready = 1; #1;
        tick();
        repair_req = 0;
        tick();
        check("pre_rst_busy", {191'b0, busy}, 192'd1);
        repair_req = 1;
        #2 rst_n = 0;
        #1;
        check("rst_async_outputs", {18'b0, obus}, 192'd0);
        tick();
        check("rst_held_outputs", {18'b0, obus}, 192'd0);
        @(negedge clk);
        rst_n = 1; repair_req = 0;
        tick();
        mem_resp_valid = 1; mem_resp_data = 32'h7777; #1;
        check("late_resp_ignored", {18'b0, obus}, 192'd0);
        tick();
        mem_resp_valid = 0;
        check("post_late_resp_idle", {18'b0, obus}, 192'd0);
        run_txn(32'h6000, 0, 1, n_req, gap, exc, fill, done);
        check("post_rst_txn", {187'b0, 5'(n_req), done, exc, fill}, {187'b0, 5'd1, 3'b101});

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/mshr_repair_ctrl.md
MSHR_REPAIR_CTRL -- requirements
Module: mshr_repair_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 256: cycles in WAIT with no response before the attempt counts as failed.
REQ-002 Parameter MAX_RETRIES, default 2: re-issues allowed after the first failed attempt.
REQ-003 Parameter RIW, default $clog2(ROB_ENTRIES) from CORE_PKG: ROB index width.
REQ-004 The block SHALL have one clock, clk; reset is rst_n, asynchronous, active-low.
REQ-005 clk  in  1  clock; rst_n  in  1  async active-low reset.
REQ-006 repair_req  in  1; repair_req_addr  in  32; repair_req_data  in  32; repair_req_rob_idx  in  RIW; repair_is_store  in  1 -- request from the MSHR.
REQ-007 repair_ack  out  1  request accepted this cycle; repair_complete  out  1  one-cycle pulse that frees the MSHR entry.
REQ-008 mem_req_valid  out  1; mem_req_ready  in  1; mem_req_addr  out  32; mem_req_we  out  1; mem_req_wdata  out  32 -- next-level request channel.
REQ-009 mem_resp_valid  in  1; mem_resp_data  in  32; mem_resp_err  in  1 -- next-level response; no backpressure.
REQ-010 fill_valid  out  1; fill_addr  out  32; fill_data  out  32 -- cache fill write.
REQ-011 wb_valid  out  1; wb_rob_idx  out  RIW; wb_data  out  32; wb_exc  out  1 -- ROB writeback.
REQ-012 busy  out  1  state is not IDLE.

Function
REQ-013 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; exactly one transaction in flight at a time.
REQ-014 IDLE: repair_ack = repair_req (combinational, same cycle); on repair_req, latch addr, data, rob_idx, is_store; clear retry count; go to ISSUE.
REQ-015 repair_ack SHALL be 0 in every state other than IDLE.
REQ-016 ISSUE: mem_req_valid=1, addr/we/wdata from latched values (we=is_store, wdata=data for stores, 0 for loads); held stable until mem_req_ready; on valid&&ready go to WAIT and clear the timer.
REQ-017 WAIT: timer increments each cycle; mem_resp_valid && !mem_resp_err -> latch mem_resp_data, error flag=0, go to RESP.
REQ-018 WAIT failure = mem_resp_valid && mem_resp_err, or timer == TIMEOUT_CYCLES-1 with no response; if retry count < MAX_RETRIES, increment it and go to ISSUE; else set error flag=1 and go to RESP.
REQ-019 A response in the same cycle the timer expires SHALL be taken as the response; the timeout is ignored.
REQ-020 mem_resp_valid outside WAIT SHALL be ignored, with no state change.
REQ-021 RESP (exactly one cycle): repair_complete=1, wb_valid=1, wb_rob_idx=latched idx, wb_exc=error flag, wb_data=response data for loads and 0 for stores; go to IDLE.
REQ-022 RESP: fill_valid=1 only when error flag=0; fill_addr=latched addr; fill_data=response data (load) or latched store data (store).
REQ-023 Minimum latency: ack at cycle 0, mem_req_valid at 1 (ready=1), response at 2, RESP at 3, next ack possible at cycle 4.
REQ-024 The retry counter SHALL be sized to hold MAX_RETRIES; the timer SHALL be sized to hold TIMEOUT_CYCLES-1 and SHALL never wrap.
REQ-025 All outputs other than repair_ack SHALL be decoded from registered state and registers only.

Reset
REQ-026 On rst_n low, immediately and regardless of clk: state=IDLE, timer=0, retry count=0, error flag=0, all latched fields 0.
REQ-027 In reset, every output SHALL be 0.
REQ-028 Reset mid-transaction SHALL abandon it with no repair_complete and no wb_valid; a late mem_resp_valid after release is ignored per REQ-020.
REQ-029 The first request SHALL be acceptable in the first clk edge after rst_n deasserts.

Verification
REQ-030 Load: req addr=0x1000, rob=5; ready=1; resp data=0xDEADBEEF at cycle 2 -> cycle 3: fill(0x1000,0xDEADBEEF), wb(rob 5, 0xDEADBEEF, exc 0), complete=1.
REQ-031 Store: addr=0x2004, data=0x12345678, rob=9; ready low 3 cycles -> mem_req held stable with we=1; after resp: fill_data=0x12345678, wb_data=0.
REQ-032 Errors: err on attempt 1 and 2, ok on 3 -> exactly 3 mem requests, wb_exc=0; err on all 3 (MAX_RETRIES=2) -> wb_exc=1, no fill_valid.
REQ-033 TIMEOUT_CYCLES=4, no response -> re-issue after 4 WAIT cycles; after 3 timeouts: wb_exc=1, complete pulse; response in the expiry cycle -> success.
REQ-034 Back-to-back: repair_req held high -> ack only in IDLE, second ack exactly 1 cycle after the first complete pulse; stray response in IDLE ignored.
REQ-035 rst_n pulsed low during WAIT -> outputs 0 at once; no complete/wb; a new request is accepted after release.
